// File: rtl/key_event_queue_if.sv
// Event read port of the key event queue: show-ahead head entry, fill level
// and the pop strobe from the consumer.
interface key_event_queue_if #(
   parameter int NUM   = 16,
   parameter int DEPTH = 8,
   parameter int IDX_W = $clog2(NUM)
);
   logic                       ev_valid;
   logic [IDX_W:0]             ev_data;
   logic [$clog2(DEPTH+1)-1:0] ev_count;
   logic                       rd_ack;

   modport master (
      output ev_valid,
      output ev_data,
      output ev_count,
      input  rd_ack
   );

   modport slave (
      input  ev_valid,
      input  ev_data,
      input  ev_count,
      output rd_ack
   );
endinterface

// File: rtl/key_event_queue.sv
// Key event queue: turns debounced key level changes into {press, index}
// events, queued in a small show-ahead FIFO. Also keeps sticky per-key
// timeout faults and a sticky overflow flag.
module key_event_queue #(
   parameter int NUM   = 16,
   parameter int DEPTH = 8,
   parameter int IDX_W = $clog2(NUM)
) (
   input  logic              clk,
   input  logic              aclr_n,
   input  logic              sclr,
   input  logic [NUM-1:0]    key,
   input  logic [NUM-1:0]    ready,
   input  logic [NUM-1:0]    timeout,
   input  logic              clr_flags,
   output logic              overflow,
   output logic [NUM-1:0]    fault,
   key_event_queue_if.master ev
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [IDX_W:0]   mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [NUM-1:0]   init;
   logic [NUM-1:0]   rep;
   logic [NUM-1:0]   diff;
   logic [IDX_W-1:0] sel;
   logic             found;
   logic             full;
   logic             push;
   logic             pop;

   // A key is pending only once its baseline is captured and its level
   // differs from the last reported one.
   assign diff = ready & init & (key ^ rep);

   // Lowest pending index wins; scanning downward lets the lowest overwrite.
   always_comb begin
      sel   = '0;
      found = 1'b0;
      for (int i = NUM - 1; i >= 0; i--) begin
         if (diff[i]) begin
            sel   = IDX_W'(i);
            found = 1'b1;
         end
      end
   end

   // Full blocks the push even when a pop happens in the same cycle.
   assign full = (count == FULL_CNT);
   assign push = found & ~full;
   assign pop  = ev.rd_ack & (count != '0);

   // Pointers, fill count, per-key baseline/report state and sticky flags.
   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         init     <= '0;
         rep      <= '0;
         fault    <= '0;
         overflow <= 1'b0;
      end else if (sclr) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         init     <= '0;
         rep      <= '0;
         fault    <= '0;
         overflow <= 1'b0;
      end else begin
         for (int i = 0; i < NUM; i++) begin
            if (!ready[i]) begin
               init[i] <= 1'b0;
            end else if (!init[i]) begin
               init[i] <= 1'b1;
               rep[i]  <= key[i];
            end
         end

         if (push) begin
            rep[sel] <= key[sel];
            wr_ptr   <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         // Set conditions win over clr_flags in the same cycle.
         fault    <= (clr_flags ? '0 : fault) | timeout;
         overflow <= (overflow & ~clr_flags) | (full & found);
      end
   end

   // Event storage; needs no reset because reads are gated by the count.
   always_ff @(posedge clk) begin
      if (push && !sclr) begin
         mem[wr_ptr] <= {key[sel], sel};
      end
   end

   assign ev.ev_valid = (count != '0);
   assign ev.ev_data  = (count != '0) ? mem[rd_ptr] : '0;
   assign ev.ev_count = count;
endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: directed scenarios followed by randomized
// traffic, all checked against a queue-based event model.
module tb_key_event_queue;
   localparam int NUM   = 16;
   localparam int DEPTH = 8;

   logic            clk = 1'b0;
   logic            aclr_n;
   logic            sclr;
   logic [NUM-1:0]  key;
   logic [NUM-1:0]  ready;
   logic [NUM-1:0]  timeout;
   logic            clr_flags;
   logic            overflow;
   logic [NUM-1:0]  fault;

   key_event_queue_if #(.NUM(NUM), .DEPTH(DEPTH)) ev_if ();

   key_event_queue #(.NUM(NUM), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .aclr_n    (aclr_n),
      .sclr      (sclr),
      .key       (key),
      .ready     (ready),
      .timeout   (timeout),
      .clr_flags (clr_flags),
      .overflow  (overflow),
      .fault     (fault),
      .ev        (ev_if)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: reported levels, baseline flags, event queue, flags.
   bit            m_init [NUM];
   bit            m_rep  [NUM];
   logic [4:0]    m_q [$];
   bit            m_ovf;
   logic [NUM-1:0] m_fault;

   task automatic model_reset();
      for (int i = 0; i < NUM; i++) begin
         m_init[i] = 0;
         m_rep[i]  = 0;
      end
      m_q.delete();
      m_ovf   = 0;
      m_fault = '0;
   endtask

   task automatic model_edge();
      int  pend;
      bit  do_push;
      if (!aclr_n || sclr) begin
         model_reset();
         return;
      end
      pend = -1;
      for (int i = 0; i < NUM; i++)
         if (pend < 0 && ready[i] && m_init[i] && (key[i] != m_rep[i])) pend = i;
      m_fault = (clr_flags ? '0 : m_fault) | timeout;
      if (clr_flags) m_ovf = 0;
      if (pend >= 0 && m_q.size() == DEPTH) m_ovf = 1;
      do_push = (pend >= 0) && (m_q.size() < DEPTH);
      if (ev_if.rd_ack && m_q.size() > 0) void'(m_q.pop_front());
      if (do_push) begin
         m_q.push_back({key[pend], 4'(pend)});
         m_rep[pend] = key[pend];
      end
      for (int i = 0; i < NUM; i++) begin
         if (!ready[i]) m_init[i] = 0;
         else if (!m_init[i]) begin
            m_init[i] = 1;
            m_rep[i]  = key[i];
         end
      end
   endtask

   // Advance one clock: model follows the active edge, return on the falling edge.
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      aclr_n = 1'b0; sclr = 1'b0; key = '0; ready = '0; timeout = '0;
      clr_flags = 1'b0; ev_if.rd_ack = 1'b0;
      model_reset();
      tick(); tick();
      n_checks++;
      if (ev_if.ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", ev_if.ev_valid); end
      n_checks++;
      if (ev_if.ev_data !== 5'd0) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", ev_if.ev_data); end
      n_checks++;
      if (ev_if.ev_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", ev_if.ev_count); end
      n_checks++;
      if (overflow !== 1'b0 || fault !== 16'h0) begin n_fail++; $display("FAIL reset_flags: got ovf=%0b fault=%0h expected 0/0", overflow, fault); end
      aclr_n = 1'b1;
      tick();
   endtask

   task automatic test_baseline();
      ready = '1;
      key   = 16'h0004;
      for (int c = 0; c < 4; c++) begin
         tick();
         n_checks++;
         if (ev_if.ev_valid !== 1'b0 || ev_if.ev_count !== 4'd0) begin
            n_fail++;
            $display("FAIL baseline_no_event: got valid=%0b count=%0d expected 0/0", ev_if.ev_valid, ev_if.ev_count);
         end
      end
   endtask

   task automatic test_single();
      key[3] = 1'b1;
      tick();
      n_checks++;
      if (ev_if.ev_valid !== 1'b1 || ev_if.ev_data !== 5'b1_0011 || ev_if.ev_count !== 4'd1) begin
         n_fail++;
         $display("FAIL single_press: got valid=%0b data=%0h count=%0d expected 1/13/1", ev_if.ev_valid, ev_if.ev_data, ev_if.ev_count);
      end
      tick();
      n_checks++;
      if (ev_if.ev_data !== 5'b1_0011 || ev_if.ev_count !== 4'd1) begin
         n_fail++;
         $display("FAIL single_hold: got data=%0h count=%0d expected 13/1", ev_if.ev_data, ev_if.ev_count);
      end
      ev_if.rd_ack = 1'b1;
      tick();
      ev_if.rd_ack = 1'b0;
      n_checks++;
      if (ev_if.ev_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop: got valid=%0b expected 0", ev_if.ev_valid); end
      ev_if.rd_ack = 1'b1;
      tick();
      ev_if.rd_ack = 1'b0;
      n_checks++;
      if (ev_if.ev_count !== 4'd0) begin n_fail++; $display("FAIL empty_ack: got count=%0d expected 0", ev_if.ev_count); end
      key[3] = 1'b0;
      tick();
      n_checks++;
      if (ev_if.ev_valid !== 1'b1 || ev_if.ev_data !== 5'b0_0011) begin
         n_fail++;
         $display("FAIL single_release: got valid=%0b data=%0h expected 1/03", ev_if.ev_valid, ev_if.ev_data);
      end
      ev_if.rd_ack = 1'b1;
      tick();
      ev_if.rd_ack = 1'b0;
   endtask

   task automatic test_simultaneous();
      key[1] = 1'b1;
      key[5] = 1'b1;
      tick();
      n_checks++;
      if (ev_if.ev_data !== 5'b1_0001 || ev_if.ev_count !== 4'd1) begin
         n_fail++;
         $display("FAIL simul_first: got data=%0h count=%0d expected 11/1", ev_if.ev_data, ev_if.ev_count);
      end
      tick();
      n_checks++;
      if (ev_if.ev_data !== 5'b1_0001 || ev_if.ev_count !== 4'd2) begin
         n_fail++;
         $display("FAIL simul_second: got data=%0h count=%0d expected 11/2", ev_if.ev_data, ev_if.ev_count);
      end
      ev_if.rd_ack = 1'b1;
      tick();
      n_checks++;
      if (ev_if.ev_data !== 5'b1_0101 || ev_if.ev_count !== 4'd1) begin
         n_fail++;
         $display("FAIL simul_order: got data=%0h count=%0d expected 15/1", ev_if.ev_data, ev_if.ev_count);
      end
      tick();
      ev_if.rd_ack = 1'b0;
      n_checks++;
      if (ev_if.ev_valid !== 1'b0) begin n_fail++; $display("FAIL simul_drain: got valid=%0b expected 0", ev_if.ev_valid); end
   endtask

   task automatic test_overflow();
      logic [4:0] exp_ev;
      for (int k = 8; k < 16; k++) begin
         key[k] = 1'b1;
         tick();
      end
      key[0] = 1'b1;
      tick();
      n_checks++;
      if (ev_if.ev_count !== 4'd8 || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_full: got count=%0d ovf=%0b expected 8/1", ev_if.ev_count, overflow);
      end
      ev_if.rd_ack = 1'b1;
      tick();
      ev_if.rd_ack = 1'b0;
      n_checks++;
      if (ev_if.ev_count !== 4'd7) begin n_fail++; $display("FAIL ovf_pop_no_push: got count=%0d expected 7", ev_if.ev_count); end
      tick();
      n_checks++;
      if (ev_if.ev_count !== 4'd8 || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_held_push: got count=%0d ovf=%0b expected 8/1", ev_if.ev_count, overflow);
      end
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      n_checks++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %0b expected 0", overflow); end
      for (int j = 0; j < 8; j++) begin
         exp_ev = (j < 7) ? {1'b1, 4'(9 + j)} : 5'b1_0000;
         n_checks++;
         if (ev_if.ev_data !== exp_ev) begin
            n_fail++;
            $display("FAIL ovf_drain[%0d]: got %0h expected %0h", j, ev_if.ev_data, exp_ev);
         end
         ev_if.rd_ack = 1'b1;
         tick();
      end
      ev_if.rd_ack = 1'b0;
      n_checks++;
      if (ev_if.ev_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got valid=%0b expected 0", ev_if.ev_valid); end
   endtask

   task automatic test_fault();
      ready[7]   = 1'b0;
      timeout[7] = 1'b1;
      key[7]     = 1'b1;
      tick();
      timeout[7] = 1'b0;
      ready[7]   = 1'b1;
      tick(); tick();
      n_checks++;
      if (fault !== 16'h0080 || ev_if.ev_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL fault_set: got fault=%0h valid=%0b expected 0080/0", fault, ev_if.ev_valid);
      end
      clr_flags  = 1'b1;
      timeout[7] = 1'b1;
      tick();
      n_checks++;
      if (fault !== 16'h0080) begin n_fail++; $display("FAIL fault_set_wins: got %0h expected 0080", fault); end
      timeout[7] = 1'b0;
      tick();
      clr_flags = 1'b0;
      n_checks++;
      if (fault !== 16'h0000) begin n_fail++; $display("FAIL fault_clear: got %0h expected 0000", fault); end
   endtask

   task automatic test_back_to_back();
      key[2] = 1'b0; tick();
      key[4] = 1'b1; tick();
      key[6] = 1'b1; tick();
      n_checks++;
      if (ev_if.ev_count !== 4'd3 || ev_if.ev_data !== 5'b0_0010) begin
         n_fail++;
         $display("FAIL b2b_fill: got count=%0d data=%0h expected 3/02", ev_if.ev_count, ev_if.ev_data);
      end
      key[3] = 1'b1;
      ev_if.rd_ack = 1'b1;
      tick();
      ev_if.rd_ack = 1'b0;
      n_checks++;
      if (ev_if.ev_count !== 4'd3 || ev_if.ev_data !== 5'b1_0100) begin
         n_fail++;
         $display("FAIL b2b_push_pop: got count=%0d data=%0h expected 3/14", ev_if.ev_count, ev_if.ev_data);
      end
      #2 aclr_n = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if (ev_if.ev_valid !== 1'b0 || ev_if.ev_count !== 4'd0 || ev_if.ev_data !== 5'd0 || fault !== 16'h0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: got valid=%0b count=%0d data=%0h expected 0/0/0", ev_if.ev_valid, ev_if.ev_count, ev_if.ev_data);
      end
      tick();
      aclr_n = 1'b1;
      tick(); tick();
      n_checks++;
      if (ev_if.ev_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_baseline: got valid=%0b expected 0", ev_if.ev_valid); end
   endtask

   task automatic test_random();
      logic [4:0] exp_data;
      int         rd_mod;
      for (int c = 0; c < 3000; c++) begin
         rd_mod = (c < 1500) ? 4 : 2;
         sclr         = ($urandom_range(0, 299) == 0);
         clr_flags    = ($urandom_range(0, 29) == 0);
         ev_if.rd_ack = ($urandom_range(0, rd_mod - 1) == 0);
         timeout      = '0;
         if ($urandom_range(0, 19) == 0) timeout[$urandom_range(0, NUM - 1)] = 1'b1;
         ready = '1;
         if ($urandom_range(0, 49) == 0) ready[$urandom_range(0, NUM - 1)] = 1'b0;
         if ($urandom_range(0, 1) == 0) key[$urandom_range(0, NUM - 1)] ^= 1'b1;
         if ($urandom_range(0, 7) == 0) key[$urandom_range(0, NUM - 1)] ^= 1'b1;
         tick();
         exp_data = (m_q.size() > 0) ? m_q[0] : 5'd0;
         n_checks++;
         if (ev_if.ev_valid !== (m_q.size() > 0)) begin n_fail++; $display("FAIL rand_valid c=%0d: got %0b expected %0b", c, ev_if.ev_valid, m_q.size() > 0); end
         n_checks++;
         if (ev_if.ev_count !== 4'(m_q.size())) begin n_fail++; $display("FAIL rand_count c=%0d: got %0d expected %0d", c, ev_if.ev_count, m_q.size()); end
         n_checks++;
         if (ev_if.ev_data !== exp_data) begin n_fail++; $display("FAIL rand_data c=%0d: got %0h expected %0h", c, ev_if.ev_data, exp_data); end
         n_checks++;
         if (overflow !== m_ovf) begin n_fail++; $display("FAIL rand_ovf c=%0d: got %0b expected %0b", c, overflow, m_ovf); end
         n_checks++;
         if (fault !== m_fault) begin n_fail++; $display("FAIL rand_fault c=%0d: got %0h expected %0h", c, fault, m_fault); end
      end
      sclr = 1'b0; clr_flags = 1'b0; ev_if.rd_ack = 1'b0; timeout = '0;
   endtask

   initial begin
      test_reset();
      test_baseline();
      test_single();
      test_simultaneous();
      test_overflow();
      test_fault();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
